image_line_streamer: RTL
========================

Name: image_line_streamer

Overview:
Pixel-domain output stage that replays image lines supplied by the line-oriented image file reader as a timed video stream.
- Generates hs/vs/de raster timing.
- Requests each active line one line period ahead with a one-cycle pulse.
- Captures the line into a ping-pong line buffer.
- Streams pixels out aligned with de.
- Sits between the file-reading source and the video sink or DUT.

Parameters:
DSIZE, 24, pixel width in bits
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch in cycles
H_SYNC, 96, horizontal sync width in cycles
H_BP, 48, horizontal back porch in cycles
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
pclk  in  1  pixel clock; the only clock
rst_n  in  1  synchronous active-low reset
line_req  out  1  one-cycle pulse requesting the next active line
wr_en  in  1  line pixel write strobe
wr_data  in  DSIZE  line pixel, written in order from x=0
wr_ovf  out  1  one-cycle pulse when a write is dropped
underrun  out  1  one-cycle pulse when a line was incomplete at swap
hs  out  1  horizontal sync
vs  out  1  vertical sync
de  out  1  data enable
data  out  DSIZE  pixel data, aligned with de
pix_x  out  clog2(H_ACTIVE)  column of the current data
pix_y  out  clog2(V_ACTIVE)  row of the current data

Behaviour:
- One clock (pclk). Reset is synchronous and active-low (rst_n sampled on the pclk rising edge).
- Totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- Counters: hcnt runs 0..H_TOTAL-1 and wraps; vcnt increments on each hcnt wrap and runs 0..V_TOTAL-1.
- Region order within a line or frame: active, front porch, sync, back porch.
- Reset: hcnt=0, vcnt=V_TOTAL-1, wr_ptr=0, both bank-full flags=0, rd_valid=0.
  - Reset output values: hs=vs=~SYNC_POL, de=0, data=0, pix_x=pix_y=0, line_req=wr_ovf=underrun=0.
  - Reset wins over every other event.
- All outputs are registered and reflect counter state (hcnt,vcnt) one cycle later.
- hs is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs uses the same rule on vcnt.
- de is asserted when hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- line_req: pulses when hcnt==0 and the next row ((vcnt+1) mod V_TOTAL) is active.
  - Row V_TOTAL-1 therefore requests row 0.
  - First pulse appears one cycle after rst_n deasserts.
- Fill side:
  - In the line_req cycle, wr_ptr resets to 0 and any concurrent write is dropped with wr_ovf.
  - Otherwise, a write with wr_ptr<H_ACTIVE stores to fill_bank[wr_ptr] and increments wr_ptr.
  - When wr_ptr reaches H_ACTIVE, the fill bank is marked full; further writes are dropped with wr_ovf until the next line_req.
- Swap: when hcnt==H_TOTAL-1 and the next row is active:
  - rd_bank <= fill bank; rd_valid <= that bank's full flag; banks exchange.
  - The new fill bank's full flag is cleared.
  - If the line was not full, underrun pulses one cycle later.
- Read side: during de, data = rd_bank[hcnt] registered, with pix_x=hcnt and pix_y=vcnt. If rd_valid=0 the whole row outputs data=0.
- Outside de, data=0 and pix_x/pix_y hold their last values.
- Storage: 2*H_ACTIVE*DSIZE, either registers or RAM inferred with 1-cycle read.

Test Plan:
(Small params: H_ACTIVE=8, H_FP=H_SYNC=H_BP=2 so H_TOTAL=14; V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 so V_TOTAL=7; DSIZE=8.)
1. Reset release, no writes -> line_req at cycle 1, then every 14 cycles for rows 0..3; de high 8 of every 14 cycles on 4 of 7 lines; underrun pulses at each active row; data=0 throughout.
2. After each line_req, write 8 pixels r*16+x -> row r shows data 0x00..0x07, 0x10..0x17, etc. with de; pix_x/pix_y match; no underrun, no wr_ovf.
3. Write 10 pixels after a line_req -> last 2 writes raise wr_ovf; line content is the first 8 pixels.
4. Write only 5 pixels for row 2 -> underrun pulse before row 2; row 2 outputs all zeros; rows 1 and 3 unaffected.
5. wr_en held high through a line_req cycle -> wr_ovf in that cycle; the next write lands at x=0.
6. Assert rst_n low mid-row 1 for 2 cycles -> outputs hit reset values the next cycle; restart with line_req one cycle after release; stale data never appears.

Source files
------------

// File: rtl/image_line_streamer.sv
// Replays externally supplied image lines as a timed hs/vs/de video stream.
// Each active line is requested one line ahead and captured into a ping-pong buffer.
module image_line_streamer #(
  parameter int DSIZE    = 24,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                          pclk,
  input  logic                          rst_n,
  output logic                          line_req,
  input  logic                          wr_en,
  input  logic [DSIZE-1:0]              wr_data,
  output logic                          wr_ovf,
  output logic                          underrun,
  output logic                          hs,
  output logic                          vs,
  output logic                          de,
  output logic [DSIZE-1:0]              data,
  output logic [$clog2(H_ACTIVE)-1:0]   pix_x,
  output logic [$clog2(V_ACTIVE)-1:0]   pix_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int PW = $clog2(H_ACTIVE + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PW-1:0] P_FULL = PW'(H_ACTIVE);
  localparam logic [PW-1:0] P_LAST = PW'(H_ACTIVE - 1);

  logic [HW-1:0]    hcnt;
  logic [VW-1:0]    vcnt;
  logic [VW-1:0]    vnext;
  logic             next_active;
  logic             h_wrap;
  logic             de_next;
  logic             hs_next;
  logic             vs_next;
  logic             swap;

  logic [PW-1:0]    wr_ptr;
  logic             wr_accept;
  logic             fill_sel;
  logic             fill_alt;
  logic             rd_sel;
  logic             rd_valid;
  logic [1:0]       full;
  logic [1:0]       full_next;

  logic [DSIZE-1:0] mem [2][H_ACTIVE];

  always_comb begin
    vnext       = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    next_active = (vnext < V_ACT);
    h_wrap      = (hcnt == H_LAST);
    de_next     = (hcnt < H_ACT) && (vcnt < V_ACT);
    hs_next     = (hcnt >= HS_BEG) && (hcnt < HS_END);
    vs_next     = (vcnt >= VS_BEG) && (vcnt < VS_END);
    swap        = h_wrap && next_active;
  end

  // Starting on the last row makes the very first line period fetch row 0.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= V_LAST;
    end else if (h_wrap) begin
      hcnt <= '0;
      vcnt <= vnext;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      hs       <= ~SYNC_POL;
      vs       <= ~SYNC_POL;
      de       <= 1'b0;
      line_req <= 1'b0;
    end else begin
      hs       <= hs_next ? SYNC_POL : ~SYNC_POL;
      vs       <= vs_next ? SYNC_POL : ~SYNC_POL;
      de       <= de_next;
      line_req <= (hcnt == '0) && next_active;
    end
  end

  // The visible line_req pulse marks the start of a new fill, so writes in it are dropped.
  always_comb begin
    fill_alt  = ~fill_sel;
    wr_accept = rst_n && wr_en && !line_req && (wr_ptr < P_FULL);
    full_next = full;
    if (wr_accept && (wr_ptr == P_LAST))
      full_next[fill_sel] = 1'b1;
    if (swap)
      full_next[fill_alt] = 1'b0;
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      full     <= '0;
      fill_sel <= 1'b0;
      rd_sel   <= 1'b0;
      rd_valid <= 1'b0;
      wr_ovf   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      wr_ovf   <= wr_en && !wr_accept;
      underrun <= swap && !full[fill_sel];
      full     <= full_next;
      if (line_req)
        wr_ptr <= '0;
      else if (wr_accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (swap) begin
        rd_sel   <= fill_sel;
        rd_valid <= full[fill_sel];
        fill_sel <= fill_alt;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (wr_accept)
      mem[fill_sel][wr_ptr[XW-1:0]] <= wr_data;
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      data  <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else if (de_next) begin
      data  <= rd_valid ? mem[rd_sel][hcnt[XW-1:0]] : '0;
      pix_x <= hcnt[XW-1:0];
      pix_y <= vcnt[YW-1:0];
    end else begin
      data <= '0;
    end
  end

endmodule
